// File: rtl/write_back_queue_if.sv
// rtl/write_back_queue_if.sv - memory-stage to write-back-queue handshake bundle
//
// Signals (direction as seen by the write-back queue, the slave):
//   valid_i        in   instruction/result presented
//   ready_o        out  queue can accept this cycle
//   instruction_i  in   retiring instruction word
//   write_value_i  in   ALU/load result
//   lr_i           in   link value for calls
interface write_back_queue_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_i;
    logic                  ready_o;
    logic [31:0]           instruction_i;
    logic [DATA_WIDTH-1:0] write_value_i;
    logic [DATA_WIDTH-1:0] lr_i;

    modport master (
        output valid_i,
        output instruction_i,
        output write_value_i,
        output lr_i,
        input  ready_o
    );

    modport slave (
        input  valid_i,
        input  instruction_i,
        input  write_value_i,
        input  lr_i,
        output ready_o
    );
endinterface

// File: rtl/write_back_queue.sv
// rtl/write_back_queue.sv - buffered write-back stage with pending-write scoreboard
//
// Queues retiring instructions (already decoded to {we, sel, value, halt})
// in a DEPTH-entry FIFO and drains one register-file write per cycle.
//
// Ports:
//   clock_i             in   clock
//   reset_i             in   synchronous active-high reset
//   up                  slave handshake bundle from the memory stage
//   rf_stall_i          in   register-file port unavailable; hold head
//   write_reg_o         out  value to write (registered)
//   select_write_reg_o  out  destination register (registered)
//   reg_write_enable_o  out  write strobe, one cycle per popped entry
//   pending_mask_o      out  bit r set while a queued entry will write r
//   halt_o              out  sticky halt, set the cycle after the halt pops
//   pc_redirect_o       out  R31 written this cycle
//
// Optional feature macro: WBQ_PC_WRITE_EN
//   defined   - ALU/load results may target R31 and pulse pc_redirect_o
//   undefined - R31 writes from ALU/load are suppressed, pc_redirect_o = 0
module write_back_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    write_back_queue_if.slave     up,
    input  logic                  rf_stall_i,
    output logic [DATA_WIDTH-1:0] write_reg_o,
    output logic [4:0]            select_write_reg_o,
    output logic                  reg_write_enable_o,
    output logic [31:0]           pending_mask_o,
    output logic                  halt_o,
    output logic                  pc_redirect_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                  q_we   [DEPTH];
    logic [4:0]            q_sel  [DEPTH];
    logic [DATA_WIDTH-1:0] q_val  [DEPTH];
    logic                  q_halt [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             halt_seen;

    logic [5:0] opcode;
    logic [4:0] dest;
    logic       is_load;
    logic       is_call;
    logic       is_crread;
    logic       is_halt;
    logic       dec_we;
    logic       push;
    logic       pop;
    logic       unused_instr_bits;

    assign opcode    = up.instruction_i[31:26];
    assign dest      = up.instruction_i[25:21];
    assign is_load   = (opcode[5:3] == 3'b100);
    assign is_call   = (opcode[5:1] == 5'b11001);
    assign is_crread = (opcode == 6'b110100);
    assign is_halt   = (opcode == 6'b111110);
    assign unused_instr_bits = ^up.instruction_i[20:0];

`ifdef WBQ_PC_WRITE_EN
    assign dec_we = is_crread | is_call | (~opcode[5] | is_load);
`else
    assign dec_we = is_crread | is_call | ((dest != 5'd31) & (~opcode[5] | is_load));
`endif

    // ready_o looks only at the pre-pop count, so a full queue never
    // accepts even when the head is leaving in the same cycle.
    assign up.ready_o = (count < CNT_W'(DEPTH)) & ~halt_seen;
    assign push       = up.valid_i & up.ready_o;
    assign pop        = (count != '0) & ~rf_stall_i;

    // Payload storage needs no reset: validity is tracked by count/pointers.
    always_ff @(posedge clock_i) begin
        if (push) begin
            q_we[wr_ptr]   <= dec_we;
            q_sel[wr_ptr]  <= is_call ? 5'd30 : dest;
            q_val[wr_ptr]  <= is_call ? up.lr_i : up.write_value_i;
            q_halt[wr_ptr] <= is_halt;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            count              <= '0;
            halt_seen          <= 1'b0;
            halt_o             <= 1'b0;
            reg_write_enable_o <= 1'b0;
            write_reg_o        <= '0;
            select_write_reg_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (is_halt) begin
                    halt_seen <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr             <= rd_ptr + PTR_W'(1);
                reg_write_enable_o <= q_we[rd_ptr];
                write_reg_o        <= q_val[rd_ptr];
                select_write_reg_o <= q_sel[rd_ptr];
                if (q_halt[rd_ptr]) begin
                    halt_o <= 1'b1;
                end
            end else begin
                reg_write_enable_o <= 1'b0;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef WBQ_PC_WRITE_EN
    logic pc_redirect_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pc_redirect_q <= 1'b0;
        end else begin
            pc_redirect_q <= pop & q_we[rd_ptr] & (q_sel[rd_ptr] == 5'd31);
        end
    end

    assign pc_redirect_o = pc_redirect_q;
`else
    assign pc_redirect_o = 1'b0;
`endif

    // An entry is live when its distance from the head is below count; the
    // entry already on the outputs has been popped and so is not included.
    always_comb begin
        logic [PTR_W-1:0] offset;
        pending_mask_o = '0;
        offset         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if (({1'b0, offset} < count) && q_we[i]) begin
                pending_mask_o[q_sel[i]] = 1'b1;
            end
        end
    end
endmodule
